// File: rtl/mdu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mult_div_unit_addsub.sv
// Ripple-carry adder/subtractor built from full-adder cells; sub=1 computes x - y
// with carry_out=1 meaning no borrow.
module full_adder (
    input  logic fa_a,
    input  logic fa_b,
    input  logic fa_cin,
    output logic fa_s,
    output logic fa_cout
);
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
endmodule

module addsub_ripple
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_y;

    assign w_c[0]    = sub;
    assign w_y       = y ^ {WIDTH{sub}};
    assign carry_out = w_c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .fa_a   (x[i]),
            .fa_b   (w_y[i]),
            .fa_cin (w_c[i]),
            .fa_s   (sum[i]),
            .fa_cout(w_c[i+1])
        );
    end
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: unsigned shift-add / restoring-divide core
// on absolute values, with a final sign-fix cycle producing HI/LO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e             r_state, w_state_nxt;
    op_e                r_op;
    logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_opnd;
    logic [CW-1:0]      r_cnt;
    logic               r_sign_lo, r_sign_hi, r_dbz;
    logic               r_done, r_div_by_zero;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_is_mul, w_sub, w_as_cout, w_fits;
    logic               w_mul_in, w_signed_in;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_as_x, w_as_sum;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_rem, w_quo;

    assign w_mul_in    = ~op[1];
    assign w_signed_in = op[0];
    assign w_abs_a     = (w_signed_in && a[WIDTH-1]) ? -a : a;
    assign w_abs_b     = (w_signed_in && b[WIDTH-1]) ? -b : b;

    assign w_is_mul = (r_op == OP_MULTU) || (r_op == OP_MULT);
    assign w_sub    = ~w_is_mul;
    // Divide trial-subtracts the low W bits of the shifted remainder; its top bit joins via w_fits.
    assign w_as_x   = w_is_mul ? r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-2:WIDTH-1];
    assign w_fits   = r_acc[2*WIDTH-1] | w_as_cout;

    addsub_ripple #(.WIDTH(WIDTH)) u_addsub (
        .sub      (w_sub),
        .x        (w_as_x),
        .y        (r_opnd),
        .sum      (w_as_sum),
        .carry_out(w_as_cout)
    );

    // The adder carry lands in the top bit after the right shift, so the
    // (2W+1)-bit multiply accumulator never needs its extra bit stored.
    always_comb begin
        w_acc_nxt = r_acc;
        if (w_is_mul) begin
            if (r_acc[0]) w_acc_nxt = {w_as_cout, w_as_sum, r_acc[WIDTH-1:1]};
            else          w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
        end else begin
            if (w_fits)   w_acc_nxt = {w_as_sum, r_acc[WIDTH-2:0], 1'b1};
            else          w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
        end
    end

    assign w_prod_fix = r_sign_lo ? -r_acc : r_acc;
    assign w_rem      = r_sign_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_quo      = r_sign_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op          <= OP_MULTU;
            r_acc         <= '0;
            r_opnd        <= '0;
            r_cnt         <= '0;
            r_sign_lo     <= 1'b0;
            r_sign_hi     <= 1'b0;
            r_dbz         <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_op          <= op_e'(op);
                    r_opnd        <= w_mul_in ? w_abs_a : w_abs_b;
                    r_acc         <= {{WIDTH{1'b0}}, (w_mul_in ? w_abs_b : w_abs_a)};
                    r_sign_lo     <= w_signed_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_sign_hi     <= w_signed_in & a[WIDTH-1];
                    r_dbz         <= ~w_mul_in & (b == '0);
                    r_div_by_zero <= 1'b0;
                    r_cnt         <= '0;
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (w_is_mul) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else begin
                        // With b=0 the remainder is |a|; its dividend-sign fix restores the raw a.
                        r_hi          <= w_rem;
                        r_lo          <= r_dbz ? '1 : w_quo;
                        r_div_by_zero <= r_dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table with a result scoreboard,
// plus hand-written sequences for ignored start and mid-operation reset.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic [7:0]   id;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, dbz;
    logic [W-1:0] hi, lo;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vec[13];

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .div_by_zero(dbz),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Scoreboard: each done pulse pops the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pending operation");
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("op%0d_hi", mon_e.id), hi, mon_e.hi);
                check($sformatf("op%0d_lo", mon_e.id), lo, mon_e.lo);
                check($sformatf("op%0d_dbz", mon_e.id), W'(dbz), W'(mon_e.dbz));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input exp_t e);
        @(negedge clk);
        op = o; a = aa; b = bb; start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check($sformatf("op%0d_busy_set", e.id), W'(busy), W'(1));
        check($sformatf("op%0d_dbz_clear", e.id), W'(dbz), W'(0));
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < 200);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d edges expected done", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   d0;
        exp_t e;

        vec[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vec[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vec[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vec[3]  = '{OP_DIVU,  32'd100,      32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
        vec[4]  = '{OP_MULTU, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0};
        vec[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vec[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vec[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vec[8]  = '{OP_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        vec[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        vec[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vec[11] = '{OP_DIVU,  32'h12345678, 32'h00000100, 32'h00000078, 32'h00123456, 1'b0};
        vec[12] = '{OP_MULTU, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0};

        #12;
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_dbz", W'(dbz), W'(0));
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: each op after the first is started in the previous done cycle.
        for (int i = 0; i < 13; i++) begin
            e = '{vec[i].hi, vec[i].lo, vec[i].dbz, 8'(i)};
            issue(vec[i].op, vec[i].a, vec[i].b, e);
            wait_done(n);
            if (i == 0) check("latency_edges", W'(n), W'(33));
            check($sformatf("op%0d_busy_at_done", i), W'(busy), W'(0));
        end

        repeat (5) @(negedge clk);
        check("hold_hi", hi, vec[12].hi);
        check("hold_lo", lo, vec[12].lo);
        check("done_pulse_cleared", W'(done), W'(0));

        // start at the 10th edge of a running op must be ignored.
        issue(OP_MULTU, 32'd7, 32'd6, '{32'd0, 32'd42, 1'b0, 8'd20});
        d0 = done_cnt;
        repeat (9) @(negedge clk);
        op = OP_DIVU; a = 32'd123; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (45) @(negedge clk);
        check("ignored_start_done_count", W'(done_cnt - d0), W'(1));
        check("ignored_start_busy", W'(busy), W'(0));

        // Reset in the middle of a divide aborts it with no result.
        issue(OP_DIVU, 32'd1000, 32'd7, '{32'd6, 32'd142, 1'b0, 8'd21});
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", W'(busy), W'(0));
        check("midreset_done", W'(done), W'(0));
        check("midreset_hi", hi, '0);
        check("midreset_lo", lo, '0);
        sb.delete();
        d0 = done_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("midreset_no_done", W'(done_cnt - d0), W'(0));

        issue(OP_DIVU, 32'd1000, 32'd7, '{32'd6, 32'd142, 1'b0, 8'd22});
        wait_done(n);
        check("post_reset_latency", W'(n), W'(33));
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_empty", W'(sb.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
